// File: rtl/pc_pred_pkg.sv
// Shared widths, BTB entry layout and helper functions for the fetch PC predictor.
// PC_PRED_BYPASS_EN (optional define) enables write-through forwarding in btb_table.
package pc_pred_pkg;

    localparam int ADDR_W     = 32;
    localparam int IDX_W      = 6;
    localparam int CNT_W      = 2;
    localparam int INST_BYTES = 4;

    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int N_ENT = 1 << IDX_W;

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_BYTES);

    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_ONE;
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CNT_W-1:0]  cnt;
    } btb_entry_t;

    function automatic logic [IDX_W-1:0] pc_idx(input logic [ADDR_W-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [ADDR_W-1:0] pc);
        return pc[ADDR_W-1:IDX_W+2];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == CNT_ZERO) ? c : c - CNT_ONE;
    endfunction

endpackage

// File: rtl/pc_predictor_btb_table.sv
// Direct-mapped BTB: valid/tag/target/direction-counter arrays, one combinational
// read port and one update port. With PC_PRED_BYPASS_EN defined, a read at the
// index being updated this cycle sees the post-update entry; otherwise it sees
// the old contents.
module btb_table
    import pc_pred_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [ADDR_W-1:0] rd_pc_in,
    output logic              rd_taken_out,
    output logic [ADDR_W-1:0] rd_target_out,
    input  logic              upd_valid_in,
    input  logic [ADDR_W-1:0] upd_pc_in,
    input  logic [ADDR_W-1:0] upd_target_in,
    input  logic              upd_taken_in,
    input  logic              upd_uncond_in
);

    logic [N_ENT-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag    [N_ENT];
    logic [ADDR_W-1:0] r_target [N_ENT];
    logic [CNT_W-1:0]  r_cnt    [N_ENT];

    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_wr_en;
    logic             w_wr_fire;
    btb_entry_t       w_upd_old;
    btb_entry_t       w_wr_entry;

    logic [IDX_W-1:0] w_rd_idx;
    btb_entry_t       w_rd_entry;

    assign w_upd_idx = pc_idx(upd_pc_in);
    assign w_upd_tag = pc_tag(upd_pc_in);
    assign w_upd_old = '{valid:  r_valid[w_upd_idx],
                         tag:    r_tag[w_upd_idx],
                         target: r_target[w_upd_idx],
                         cnt:    r_cnt[w_upd_idx]};
    assign w_upd_hit = w_upd_old.valid && (w_upd_old.tag == w_upd_tag);
    assign w_wr_fire = rdy_in && w_wr_en;

    // Build the new entry for the update index; not-taken misses leave the table alone.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_entry = w_upd_old;
        if (upd_valid_in) begin
            if (upd_uncond_in) begin
                w_wr_en           = 1'b1;
                w_wr_entry.valid  = 1'b1;
                w_wr_entry.tag    = w_upd_tag;
                w_wr_entry.target = upd_target_in;
                w_wr_entry.cnt    = CNT_MAX;
            end else if (upd_taken_in && w_upd_hit) begin
                w_wr_en           = 1'b1;
                w_wr_entry.target = upd_target_in;
                w_wr_entry.cnt    = cnt_inc(w_upd_old.cnt);
            end else if (upd_taken_in) begin
                w_wr_en           = 1'b1;
                w_wr_entry.valid  = 1'b1;
                w_wr_entry.tag    = w_upd_tag;
                w_wr_entry.target = upd_target_in;
                w_wr_entry.cnt    = CNT_WEAK_T;
            end else if (w_upd_hit) begin
                w_wr_en           = 1'b1;
                w_wr_entry.cnt    = cnt_dec(w_upd_old.cnt);
            end
        end
    end

    assign w_rd_idx = pc_idx(rd_pc_in);

    // Read port, optionally forwarding the entry being written this cycle.
    always_comb begin
        w_rd_entry = '{valid:  r_valid[w_rd_idx],
                       tag:    r_tag[w_rd_idx],
                       target: r_target[w_rd_idx],
                       cnt:    r_cnt[w_rd_idx]};
`ifdef PC_PRED_BYPASS_EN
        if (w_wr_fire && (w_upd_idx == w_rd_idx)) begin
            w_rd_entry = w_wr_entry;
        end
`else
        w_rd_entry = w_rd_entry;
`endif
    end

    assign rd_taken_out  = w_rd_entry.valid && (w_rd_entry.tag == pc_tag(rd_pc_in))
                           && w_rd_entry.cnt[CNT_W-1];
    assign rd_target_out = w_rd_entry.target;

    // Valid bits and counters: cleared in a single reset cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid <= '0;
            for (int i = 0; i < N_ENT; i++) begin
                r_cnt[i] <= CNT_WEAK_NT;
            end
        end else if (w_wr_fire) begin
            r_valid[w_upd_idx] <= w_wr_entry.valid;
            r_cnt[w_upd_idx]   <= w_wr_entry.cnt;
        end
    end

    // Tag/target storage carries no reset; stale data is masked by the valid bits.
    always_ff @(posedge clk_in) begin
        if (!rst_in && w_wr_fire) begin
            r_tag[w_upd_idx]    <= w_wr_entry.tag;
            r_target[w_upd_idx] <= w_wr_entry.target;
        end
    end

endmodule

// File: rtl/pc_predictor.sv
// Fetch PC generator: holds the current fetch PC and its predicted successor,
// looked up in btb_table one cycle ahead. Redirects win over stall.
// Optional define PC_PRED_BYPASS_EN enables same-cycle update forwarding in the BTB.
module pc_predictor
    import pc_pred_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              stall_in,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] redirect_pc_in,
    input  logic              upd_valid_in,
    input  logic [ADDR_W-1:0] upd_pc_in,
    input  logic [ADDR_W-1:0] upd_target_in,
    input  logic              upd_taken_in,
    input  logic              upd_uncond_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pred_taken_out,
    output logic [ADDR_W-1:0] pred_next_pc_out
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pred_next;
    logic              r_pred_taken;

    logic [ADDR_W-1:0] w_lookup_pc;
    logic              w_lu_taken;
    logic [ADDR_W-1:0] w_lu_target;
    logic [ADDR_W-1:0] w_lu_next;
    logic              w_advance;

    // The PC that becomes pc_out next is the one looked up this cycle.
    assign w_lookup_pc = redirect_in ? redirect_pc_in : r_pred_next;
    assign w_lu_next   = w_lu_taken ? w_lu_target : (w_lookup_pc + PC_INC);
    assign w_advance   = redirect_in || !stall_in;

    btb_table u_btb (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .rd_pc_in      (w_lookup_pc),
        .rd_taken_out  (w_lu_taken),
        .rd_target_out (w_lu_target),
        .upd_valid_in  (upd_valid_in),
        .upd_pc_in     (upd_pc_in),
        .upd_target_in (upd_target_in),
        .upd_taken_in  (upd_taken_in),
        .upd_uncond_in (upd_uncond_in)
    );

    // PC sequencing: advance on redirect or unstalled cycle, freeze when not ready.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pc         <= '0;
            r_pred_next  <= PC_INC;
            r_pred_taken <= 1'b0;
        end else if (rdy_in && w_advance) begin
            r_pc         <= w_lookup_pc;
            r_pred_next  <= w_lu_next;
            r_pred_taken <= w_lu_taken;
        end
    end

    assign pc_out           = r_pc;
    assign pred_next_pc_out = r_pred_next;
    assign pred_taken_out   = r_pred_taken;

endmodule

// File: tb/tb_pc_predictor.sv
// Self-checking bench for pc_predictor: table of per-cycle vectors with the
// expected post-edge outputs queued at drive time and compared after the edge.
module tb_pc_predictor;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        upd_valid_in;
    logic [31:0] upd_pc_in;
    logic [31:0] upd_target_in;
    logic        upd_taken_in;
    logic        upd_uncond_in;
    logic [31:0] pc_out;
    logic        pred_taken_out;
    logic [31:0] pred_next_pc_out;

`ifdef PC_PRED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    pc_predictor dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .stall_in         (stall_in),
        .redirect_in      (redirect_in),
        .redirect_pc_in   (redirect_pc_in),
        .upd_valid_in     (upd_valid_in),
        .upd_pc_in        (upd_pc_in),
        .upd_target_in    (upd_target_in),
        .upd_taken_in     (upd_taken_in),
        .upd_uncond_in    (upd_uncond_in),
        .pc_out           (pc_out),
        .pred_taken_out   (pred_taken_out),
        .pred_next_pc_out (pred_next_pc_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy, stall, redir;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc, utgt;
        logic        ut, uu;
        logic [31:0] e_pc;
        logic        e_t;
        logic [31:0] e_next;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        t;
        logic [31:0] nx;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic rdy, stall, redir, input logic [31:0] rpc,
                                input logic uv, input logic [31:0] upc, utgt,
                                input logic ut, uu, input logic [31:0] e_pc,
                                input logic e_t, input logic [31:0] e_next);
        vec_t v;
        v = '{rdy, stall, redir, rpc, uv, upc, utgt, ut, uu, e_pc, e_t, e_next};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty got 1 expected 0", nm);
        end else begin
            e = sbq.pop_front();
            chk({nm, ".pc"},    pc_out,                  e.pc);
            chk({nm, ".taken"}, {31'd0, pred_taken_out}, {31'd0, e.t});
            chk({nm, ".next"},  pred_next_pc_out,        e.nx);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        rdy_in         = v.rdy;
        stall_in       = v.stall;
        redirect_in    = v.redir;
        redirect_pc_in = v.rpc;
        upd_valid_in   = v.uv;
        upd_pc_in      = v.upc;
        upd_target_in  = v.utgt;
        upd_taken_in   = v.ut;
        upd_uncond_in  = v.uu;
        e = '{v.e_pc, v.e_t, v.e_next};
        sbq.push_back(e);
        @(posedge clk_in);
        #1;
        check_out(nm);
        @(negedge clk_in);
    endtask

    initial begin
        exp_t e;
        vec_t v;

        // rdy stall redir rpc | uv upc utgt ut uu | exp pc taken next
        add(1,0,0,0,          0,0,0,0,0,             32'h4,   0, 32'h8);
        add(1,0,0,0,          0,0,0,0,0,             32'h8,   0, 32'hC);
        add(1,0,0,0,          1,32'h10,32'h40,1,0,   32'hC,   0, 32'h10);
        add(1,0,0,0,          0,0,0,0,0,             32'h10,  1, 32'h40);
        add(1,0,0,0,          0,0,0,0,0,             32'h40,  0, 32'h44);
        add(1,1,0,0,          1,32'h10,0,0,0,        32'h40,  0, 32'h44);
        add(1,1,0,0,          1,32'h10,0,0,0,        32'h40,  0, 32'h44);
        add(1,1,0,0,          1,32'h10,0,0,0,        32'h40,  0, 32'h44);
        add(1,0,1,32'h10,     0,0,0,0,0,             32'h10,  0, 32'h14);
        add(1,1,0,0,          1,32'h10,32'h80,1,0,   32'h10,  0, 32'h14);
        add(1,0,1,32'h10,     0,0,0,0,0,             32'h10,  0, 32'h14);
        add(1,1,0,0,          1,32'h10,32'h80,1,0,   32'h10,  0, 32'h14);
        add(1,0,1,32'h10,     0,0,0,0,0,             32'h10,  1, 32'h80);
        add(1,1,0,0,          1,32'h10,32'h90,0,1,   32'h10,  1, 32'h80);
        add(1,1,0,0,          1,32'h10,32'h90,1,0,   32'h10,  1, 32'h80);
        add(1,1,0,0,          1,32'h10,0,0,0,        32'h10,  1, 32'h80);
        add(1,0,1,32'h10,     0,0,0,0,0,             32'h10,  1, 32'h90);
        add(1,1,0,0,          1,32'h110,32'hA0,1,0,  32'h10,  1, 32'h90);
        add(1,0,1,32'h10,     0,0,0,0,0,             32'h10,  0, 32'h14);
        add(1,0,1,32'h110,    0,0,0,0,0,             32'h110, 1, 32'hA0);
        add(1,0,0,0,          0,0,0,0,0,             32'hA0,  0, 32'hA4);
        add(1,1,1,32'h200,    0,0,0,0,0,             32'h200, 0, 32'h204);
        add(0,0,0,0,          1,32'h204,32'h300,1,0, 32'h200, 0, 32'h204);
        add(0,0,0,0,          1,32'h204,32'h300,1,0, 32'h200, 0, 32'h204);
        add(0,0,1,32'h400,    1,32'h204,32'h300,1,0, 32'h200, 0, 32'h204);
        add(1,0,0,0,          0,0,0,0,0,             32'h204, 0, 32'h208);
        add(1,0,1,32'hFFFFFFFC,0,0,0,0,0,            32'hFFFFFFFC, 0, 32'h0);
        add(1,0,0,0,          0,0,0,0,0,             32'h0,   0, 32'h4);
        add(1,0,0,0,          0,0,0,0,0,             32'h4,   0, 32'h8);
        add(1,0,0,0,          1,32'h8,32'h100,0,1,   32'h8,   BYP, BYP ? 32'h100 : 32'hC);
        add(1,0,1,32'h8,      0,0,0,0,0,             32'h8,   1, 32'h100);

        rst_in = 1'b1; rdy_in = 1'b1; stall_in = 1'b0; redirect_in = 1'b0;
        redirect_pc_in = '0; upd_valid_in = 1'b0; upd_pc_in = '0;
        upd_target_in = '0; upd_taken_in = 1'b0; upd_uncond_in = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        e = '{32'h0, 1'b0, 32'h4};
        sbq.push_back(e);
        check_out("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-run overrides a concurrent redirect and update.
        rst_in = 1'b1;
        v = '{1, 0, 1, 32'h300, 1, 32'h300, 32'h500, 0, 1, 32'h0, 0, 32'h4};
        apply(v, "mid_reset");
        rst_in = 1'b0;
        v = '{1, 0, 1, 32'h300, 0, 0, 0, 0, 0, 32'h300, 0, 32'h304};
        apply(v, "post_reset_300");
        v = '{1, 0, 1, 32'h8, 0, 0, 0, 0, 0, 32'h8, 0, 32'hC};
        apply(v, "post_reset_8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
